xor_parity_sched: RTL and testbench

Round-robin scheduler that shares one 3-input XOR gate (the team's `xor_gate`, ports x1/x2/x3/y) among several requesters to compute the parity of multi-bit words. Each granted word is fed into the shared gate two bits per cycle, with the running parity on the third input. The result is returned with the index of the requester that owns it. The block sits between the requesting datapath units and the single shared XOR instance, and owns all sequencing of that gate.

---
 rtl/xor_parity_sched_if.sv | 16 +
 rtl/xor_parity_sched.sv | 81 ++++++++
 tb/tb_xor_parity_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/xor_parity_sched_if.sv
// xor_parity_sched_if: requester/result bus plus the pins of the shared xor_gate.
interface xor_parity_sched_if #(parameter int N_REQ = 4, parameter int ID_W = 2, parameter int WIDTH = 8);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   xor_a;
  logic                   xor_b;
  logic                   xor_c;
  logic                   xor_y;
  logic                   done;
  logic                   parity;
  logic [ID_W-1:0]        done_id;
  modport master(output req, data, xor_y, input gnt, busy, xor_a, xor_b, xor_c, done, parity, done_id);
  modport slave(input req, data, xor_y, output gnt, busy, xor_a, xor_b, xor_c, done, parity, done_id);
endinterface

// File: rtl/xor_parity_sched.sv
// xor_parity_sched: round-robin sharing of one 3-input XOR gate to compute word parity, two bits per cycle.
module xor_parity_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  xor_parity_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH/2 + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sh;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  win;
  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    logic hit;
    win = last;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int j;
      j = (int'(last) + k) % N_REQ;
      if (!hit && bus.req[j]) begin
        win = ID_W'(j);
        hit = 1'b1;
      end
    end
  end
  // The gate only sees data while RUN; acc closes the loop through the external xor_y.
  assign bus.xor_a = (state == RUN) & sh[0];
  assign bus.xor_b = (state == RUN) & sh[1];
  assign bus.xor_c = (state == RUN) & acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      acc         <= 1'b0;
      cnt         <= '0;
      last        <= ID_W'(N_REQ - 1);
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.parity  <= 1'b0;
      bus.done_id <= '0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          sh       <= bus.data[win*WIDTH +: WIDTH];
          acc      <= 1'b0;
          cnt      <= '0;
          last     <= win;
          bus.gnt  <= N_REQ'(1) << win;
          bus.busy <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          acc <= bus.xor_y;
          sh  <= sh >> 2;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH/2 - 1)) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.parity  <= bus.xor_y;
            bus.done_id <= last;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_parity_sched.sv
// tb_xor_parity_sched: directed scenario tasks against hand-computed parities, grant order and timing.
module tb_xor_parity_sched;
  localparam int N = 4, IW = 2, W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, cyc = 0;
  xor_parity_sched_if #(.N_REQ(N), .ID_W(IW), .WIDTH(W)) bus();
  xor_parity_sched #(.N_REQ(N), .ID_W(IW), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.xor_y = bus.xor_a ^ bus.xor_b ^ bus.xor_c;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = (bus.gnt != '0);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = bus.done;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.data = '0;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.data = '0;
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({bus.gnt, bus.busy, bus.xor_a, bus.xor_b, bus.xor_c, bus.done, bus.parity, bus.done_id} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got gnt=%b busy=%b abc=%b%b%b done=%b par=%b id=%0d want all 0",
        bus.gnt, bus.busy, bus.xor_a, bus.xor_b, bus.xor_c, bus.done, bus.parity, bus.done_id);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({bus.busy, bus.gnt, bus.done} !== '0) begin
      n_err++; $display("FAIL idle_quiet: got busy=%b gnt=%b done=%b want 0", bus.busy, bus.gnt, bus.done);
    end
  endtask

  task automatic test_even();
    bus.data = 32'h0000_00A5;
    bus.req = 4'b0001;
    tick();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL even_gnt: got %b want 0001", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL even_busy: got %b want 1", bus.busy); end
    n_cmp++; if ({bus.xor_a, bus.xor_b, bus.xor_c} !== 3'b100) begin
      n_err++; $display("FAIL even_abc0: got %b%b%b want 100", bus.xor_a, bus.xor_b, bus.xor_c);
    end
    bus.req = '0;
    tick();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL even_gnt_pulse: got %b want 0000", bus.gnt); end
    repeat (3) tick();
    n_cmp++; if ({bus.done, bus.parity, bus.done_id} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL even_result: got done=%b par=%b id=%0d want 1 0 0", bus.done, bus.parity, bus.done_id);
    end
    tick();
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin
      n_err++; $display("FAIL even_end: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_odd();
    logic [2:0] seq [4] = '{3'b110, 3'b100, 3'b001, 3'b001};
    bus.data = 32'h0007_0000;
    bus.req = 4'b0100;
    tick();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL odd_gnt: got %b want 0100", bus.gnt); end
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.xor_a, bus.xor_b, bus.xor_c} !== seq[i]) begin
        n_err++; $display("FAIL odd_abc%0d: got %b%b%b want %b", i, bus.xor_a, bus.xor_b, bus.xor_c, seq[i]);
      end
      tick();
    end
    n_cmp++; if ({bus.done, bus.parity, bus.done_id} !== {1'b1, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL odd_result: got done=%b par=%b id=%0d want 1 1 2", bus.done, bus.parity, bus.done_id);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] p = 4'b1010;
    bit ok;
    int t_prev = 0;
    do_reset();
    bus.data = {8'h80, 8'h00, 8'h01, 8'hFF};
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(ok);
      n_cmp++; if (!ok || bus.gnt !== 4'(1) << i) begin
        n_err++; $display("FAIL cont_gnt%0d: got %b want %b", i, bus.gnt, 4'(1) << i);
      end
      if (i > 0) begin
        n_cmp++; if (cyc - t_prev !== 6) begin n_err++; $display("FAIL cont_gap%0d: got %0d want 6", i, cyc - t_prev); end
      end
      t_prev = cyc;
      bus.req[i] = 1'b0;
      wait_done(ok);
      n_cmp++; if (!ok || bus.parity !== p[i] || bus.done_id !== IW'(i)) begin
        n_err++; $display("FAIL cont_res%0d: got done=%b par=%b id=%0d want 1 %b %0d", i, bus.done, bus.parity, bus.done_id, p[i], i);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    bit ok;
    bus.data = {8'h01, 8'h00, 8'h00, 8'h03};
    bus.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(ok);
      n_cmp++; if (!ok || bus.gnt !== exp[i]) begin
        n_err++; $display("FAIL fair_gnt%0d: got %b want %b", i, bus.gnt, exp[i]);
      end
      if (i == 3) bus.req = '0;
    end
    repeat (6) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fair_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit sd = 1'b0;
    bit sg = 1'b0;
    bus.data = 32'h0000_01A5;
    bus.req = 4'b0001;
    wait_gnt(ok);
    n_cmp++; if (!ok || bus.gnt !== 4'b0001) begin n_err++; $display("FAIL rst_gnt: got %b want 0001", bus.gnt); end
    bus.req = '0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.gnt, bus.busy, bus.xor_a, bus.xor_b, bus.xor_c, bus.done, bus.parity, bus.done_id} !== '0) begin
      n_err++; $display("FAIL rst_async: got busy=%b abc=%b%b%b done=%b want all 0", bus.busy, bus.xor_a, bus.xor_b, bus.xor_c, bus.done);
    end
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin
      tick();
      sd |= bus.done;
      sg |= (bus.gnt != '0);
    end
    n_cmp++; if ({sd, sg} !== 2'b00) begin n_err++; $display("FAIL rst_no_done: got done=%b gnt=%b want 0 0", sd, sg); end
    bus.req = 4'b0011;
    wait_gnt(ok);
    n_cmp++; if (!ok || bus.gnt !== 4'b0001) begin n_err++; $display("FAIL rst_prio: got %b want 0001", bus.gnt); end
    bus.req = '0;
    wait_done(ok);
    n_cmp++; if (!ok || bus.done_id !== 2'd0 || bus.parity !== 1'b0) begin
      n_err++; $display("FAIL rst_res: got id=%0d par=%b want 0 0", bus.done_id, bus.parity);
    end
    repeat (2) tick();
  endtask

  task automatic test_drop_busy();
    bit ok;
    int ng = 0, nd = 0;
    logic xbad = 1'b0;
    logic [IW-1:0] id = '1;
    logic par = 1'b1;
    bus.data = {8'hFF, 8'h00, 8'h55, 8'h00};
    bus.req = 4'b1000;
    wait_gnt(ok);
    n_cmp++; if (!ok || bus.gnt !== 4'b1000) begin n_err++; $display("FAIL drop_gnt: got %b want 1000", bus.gnt); end
    bus.req = '0;
    tick();
    bus.req[1] = 1'b1;
    repeat (2) tick();
    bus.req = '0;
    repeat (10) begin
      tick();
      if (bus.gnt != '0) ng++;
      if (bus.done) begin nd++; id = bus.done_id; par = bus.parity; end
      if (!bus.busy && (bus.xor_a | bus.xor_b | bus.xor_c)) xbad = 1'b1;
    end
    n_cmp++; if (ng !== 0) begin n_err++; $display("FAIL drop_no_gnt: got %0d grants want 0", ng); end
    n_cmp++; if (nd !== 1 || id !== 2'd3 || par !== 1'b0) begin
      n_err++; $display("FAIL drop_done: got n=%0d id=%0d par=%b want 1 3 0", nd, id, par);
    end
    n_cmp++; if (xbad !== 1'b0) begin n_err++; $display("FAIL idle_xor: got nonzero want 000"); end
  endtask

  initial begin
    bus.req = '0;
    bus.data = '0;
    test_reset();
    test_even();
    test_odd();
    test_contention();
    test_fairness();
    test_reset_mid_run();
    test_drop_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
